ddr_cmd_phy_encoder: RTL and testbench

- Parametrised successor to the init-only DDR3 command PHY.
- Accepts one abstract command per valid/ready handshake from the command scheduler or init FSM.
- Encodes the full DDR3 command set (MRS, REF, PRE, ACT, WR, RD, ZQCL, RESET, POWER_UP) onto the pins, across RANKS chip selects.
- Holds off further commands by back-pressure until the command-specific minimum spacing has elapsed; NOPs are driven while waiting.

---
 rtl/ddr_cmd_phy_encoder.sv | 236 +++++++++++++++++++++++
 tb/tb_ddr_cmd_phy_encoder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_cmd_phy_encoder.sv
// DDR3 command PHY encoder.
// Takes one abstract command per valid/ready handshake and drives it onto the
// DRAM command pins for exactly one cycle, then reverts to NOP. A spacing
// counter holds off the next command until the command-specific minimum gap
// has elapsed.
//
// Handshake: a command is accepted on a posedge where i_cmd_valid and
// o_cmd_ready are both high. i_cmd/i_rank/i_ba/i_addr/i_mr_sel are sampled
// only on that edge. o_cmd_ready does not depend on i_cmd_valid.
module ddr_cmd_phy_encoder #(
    parameter int          ADDR_BITS = 14,
    parameter int          BA_BITS   = 3,
    parameter int          RANKS     = 1,
    parameter logic [15:0] MR0_VAL   = 16'h1D70,
    parameter logic [15:0] MR1_VAL   = 16'h0006,
    parameter logic [15:0] MR2_VAL   = 16'h0018,
    parameter logic [15:0] MR3_VAL   = 16'h0000,
    parameter int          T_MOD     = 12,
    parameter int          T_RFC     = 88,
    parameter int          T_RP      = 6,
    parameter int          T_RCD     = 6,
    parameter int          T_CCD     = 4,
    parameter int          T_ZQINIT  = 512,
    // Derived from RANKS; leave at its default.
    parameter int          RANK_W    = (RANKS > 1) ? $clog2(RANKS) : 1
) (
    input  logic                 clk1,
    input  logic                 rst,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic [3:0]           i_cmd,
    input  logic [RANK_W-1:0]    i_rank,
    input  logic [BA_BITS-1:0]   i_ba,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [1:0]           i_mr_sel,
    output logic                 cke,
    output logic [RANKS-1:0]     cs_n,
    output logic                 ras_n,
    output logic                 cas_n,
    output logic                 we_n,
    output logic [BA_BITS-1:0]   ba,
    output logic [ADDR_BITS-1:0] addr,
    output logic                 o_illegal
);

    typedef enum logic [3:0] {
        CMD_NOP      = 4'd0,
        CMD_MRS      = 4'd1,
        CMD_REF      = 4'd2,
        CMD_PRE      = 4'd3,
        CMD_ACT      = 4'd4,
        CMD_WR       = 4'd5,
        CMD_RD       = 4'd6,
        CMD_ZQCL     = 4'd7,
        CMD_RESET    = 4'd8,
        CMD_POWER_UP = 4'd9
    } cmd_e;

    function automatic int clamp1(input int t);
        return (t < 1) ? 1 : t;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Zero timings behave as one cycle (back-to-back allowed).
    localparam int TMOD = clamp1(T_MOD);
    localparam int TRFC = clamp1(T_RFC);
    localparam int TRP  = clamp1(T_RP);
    localparam int TRCD = clamp1(T_RCD);
    localparam int TCCD = clamp1(T_CCD);
    localparam int TZQ  = clamp1(T_ZQINIT);
    localparam int TMAX = max2(max2(max2(TMOD, TRFC), max2(TRP, TRCD)), max2(TCCD, TZQ));
    localparam int CNT_W = $clog2(TMAX + 1);

    // Counter is loaded with T-1 so the next accept lands exactly T cycles later.
    localparam logic [CNT_W-1:0] LD_MOD = CNT_W'(TMOD - 1);
    localparam logic [CNT_W-1:0] LD_RFC = CNT_W'(TRFC - 1);
    localparam logic [CNT_W-1:0] LD_RP  = CNT_W'(TRP - 1);
    localparam logic [CNT_W-1:0] LD_RCD = CNT_W'(TRCD - 1);
    localparam logic [CNT_W-1:0] LD_CCD = CNT_W'(TCCD - 1);
    localparam logic [CNT_W-1:0] LD_ZQ  = CNT_W'(TZQ - 1);

    // ZQCL long calibration: A10 high, all other address bits low.
    localparam logic [ADDR_BITS-1:0] ZQ_ADDR = ADDR_BITS'(1) << 10;

    logic [CNT_W-1:0]     cnt;
    logic                 accept;
    logic                 rank_ok;
    logic [RANKS-1:0]     rank_sel_n;
    logic [ADDR_BITS-1:0] mr_payload;

    logic                 nxt_cke;
    logic [RANKS-1:0]     nxt_cs_n;
    logic [2:0]           nxt_rcw;
    logic [BA_BITS-1:0]   nxt_ba;
    logic [ADDR_BITS-1:0] nxt_addr;
    logic                 nxt_illegal;
    logic                 load_en;
    logic [CNT_W-1:0]     load_val;

    assign o_cmd_ready = ~rst & (cnt == '0);
    assign accept      = i_cmd_valid & o_cmd_ready;
    assign rank_ok     = (32'(i_rank) < RANKS);
    assign rank_sel_n  = ~(RANKS'(1) << i_rank);

    // Select the mode-register payload for MRS.
    always_comb begin
        case (i_mr_sel)
            2'd0:    mr_payload = ADDR_BITS'(MR0_VAL);
            2'd1:    mr_payload = ADDR_BITS'(MR1_VAL);
            2'd2:    mr_payload = ADDR_BITS'(MR2_VAL);
            default: mr_payload = ADDR_BITS'(MR3_VAL);
        endcase
    end

    // Decode the accepted command into next pin values and spacing load.
    // Without an accept the pins fall back to NOP on the current chip selects.
    always_comb begin
        nxt_cke     = cke;
        nxt_cs_n    = cs_n;
        nxt_rcw     = 3'b111;
        nxt_ba      = ba;
        nxt_addr    = addr;
        nxt_illegal = 1'b0;
        load_en     = 1'b0;
        load_val    = '0;
        if (accept) begin
            case (i_cmd)
                CMD_NOP: begin
                    nxt_illegal = 1'b0;
                end
                CMD_RESET: begin
                    nxt_cke  = 1'b0;
                    nxt_cs_n = '1;
                    nxt_ba   = '0;
                    nxt_addr = '0;
                end
                CMD_POWER_UP: begin
                    nxt_cke  = 1'b1;
                    nxt_cs_n = '0;
                end
                CMD_MRS, CMD_REF, CMD_PRE, CMD_ACT, CMD_WR, CMD_RD, CMD_ZQCL: begin
                    // Rank-targeted commands need a powered-up device and a real rank.
                    if (!cke || !rank_ok) begin
                        nxt_illegal = 1'b1;
                    end else begin
                        nxt_cs_n = rank_sel_n;
                        load_en  = 1'b1;
                        case (i_cmd)
                            CMD_MRS: begin
                                nxt_rcw  = 3'b000;
                                nxt_ba   = BA_BITS'(i_mr_sel);
                                nxt_addr = mr_payload;
                                load_val = LD_MOD;
                            end
                            CMD_REF: begin
                                nxt_rcw  = 3'b001;
                                load_val = LD_RFC;
                            end
                            CMD_PRE: begin
                                nxt_rcw  = 3'b010;
                                nxt_ba   = i_ba;
                                nxt_addr = i_addr;
                                load_val = LD_RP;
                            end
                            CMD_ACT: begin
                                nxt_rcw  = 3'b011;
                                nxt_ba   = i_ba;
                                nxt_addr = i_addr;
                                load_val = LD_RCD;
                            end
                            CMD_WR: begin
                                nxt_rcw  = 3'b100;
                                nxt_ba   = i_ba;
                                nxt_addr = i_addr;
                                load_val = LD_CCD;
                            end
                            CMD_RD: begin
                                nxt_rcw  = 3'b101;
                                nxt_ba   = i_ba;
                                nxt_addr = i_addr;
                                load_val = LD_CCD;
                            end
                            default: begin
                                nxt_rcw  = 3'b110;
                                nxt_ba   = '0;
                                nxt_addr = ZQ_ADDR;
                                load_val = LD_ZQ;
                            end
                        endcase
                    end
                end
                default: begin
                    nxt_illegal = 1'b1;
                end
            endcase
        end
    end

    // Spacing counter: load on a timed command, otherwise count down to zero.
    always_ff @(posedge clk1) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept && load_en) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Pin register: every DRAM pin is a flop output.
    always_ff @(posedge clk1) begin
        if (rst) begin
            cke       <= 1'b0;
            cs_n      <= '1;
            ras_n     <= 1'b1;
            cas_n     <= 1'b1;
            we_n      <= 1'b1;
            ba        <= '0;
            addr      <= '0;
            o_illegal <= 1'b0;
        end else begin
            cke       <= nxt_cke;
            cs_n      <= nxt_cs_n;
            ras_n     <= nxt_rcw[2];
            cas_n     <= nxt_rcw[1];
            we_n      <= nxt_rcw[0];
            ba        <= nxt_ba;
            addr      <= nxt_addr;
            o_illegal <= nxt_illegal;
        end
    end

endmodule

// File: tb/tb_ddr_cmd_phy_encoder.sv
// Directed bench for ddr_cmd_phy_encoder: a vector table of single commands
// (pins in the command cycle, accept-to-ready gap, NOP reversion) plus
// hand-written multi-cycle sequences.
module tb_ddr_cmd_phy_encoder;

    typedef struct {
        logic [3:0]  cmd;
        logic [1:0]  rank;
        logic [2:0]  ba;
        logic [13:0] addr;
        logic [1:0]  mr;
        logic        e_cke;
        logic [1:0]  e_cs;
        logic [2:0]  e_rcw;
        logic [2:0]  e_ba;
        logic [13:0] e_addr;
        logic        e_ill;
        int          e_gap;
    } vec_t;

    localparam int NVEC = 17;

    // clock / reset and shared stimulus
    logic        clk1    = 1'b0;
    logic        rst     = 1'b1;
    logic        valid   = 1'b0;
    logic        valid3  = 1'b0;
    logic [3:0]  cmd     = 4'd0;
    logic [1:0]  rank    = 2'd0;
    logic [2:0]  ba_in   = 3'd0;
    logic [13:0] addr_in = 14'd0;
    logic [1:0]  mr_sel  = 2'd0;

    // two-rank instance, T_CCD = 1
    logic        ready, cke, ras_n, cas_n, we_n, illegal;
    logic [1:0]  cs_n;
    logic [2:0]  ba;
    logic [13:0] addr;

    // three-rank instance, used for the out-of-range rank case
    logic        ready3, cke3, ras3, cas3, we3, illegal3;
    logic [2:0]  cs3;
    logic [2:0]  ba3;
    logic [13:0] addr3;

    int   n_vec  = 0;
    int   n_fail = 0;
    vec_t vecs[NVEC];

    always #5 clk1 = ~clk1;

    ddr_cmd_phy_encoder #(.RANKS(2), .T_CCD(1)) dut (
        .clk1(clk1), .rst(rst), .i_cmd_valid(valid), .o_cmd_ready(ready),
        .i_cmd(cmd), .i_rank(rank[0]), .i_ba(ba_in), .i_addr(addr_in), .i_mr_sel(mr_sel),
        .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
        .ba(ba), .addr(addr), .o_illegal(illegal)
    );

    ddr_cmd_phy_encoder #(.RANKS(3)) dut3 (
        .clk1(clk1), .rst(rst), .i_cmd_valid(valid3), .o_cmd_ready(ready3),
        .i_cmd(cmd), .i_rank(rank), .i_ba(ba_in), .i_addr(addr_in), .i_mr_sel(mr_sel),
        .cke(cke3), .cs_n(cs3), .ras_n(ras3), .cas_n(cas3), .we_n(we3),
        .ba(ba3), .addr(addr3), .o_illegal(illegal3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pins();
        return 32'({cke, cs_n, ras_n, cas_n, we_n, ba, addr, illegal});
    endfunction

    function automatic logic [31:0] mkp(input logic k, input logic [1:0] c, input logic [2:0] r,
                                        input logic [2:0] b, input logic [13:0] a, input logic il);
        return 32'({k, c, r, b, a, il});
    endfunction

    function automatic logic [31:0] pins3();
        return 32'({cke3, cs3, ras3, cas3, we3, ba3, addr3, illegal3});
    endfunction

    // Called at a negedge; returns once ready is high or the budget runs out.
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!ready && n < 2000) begin
            @(negedge clk1);
            n++;
        end
        if (n >= 2000) chk({name, "_ready_timeout"}, 32'(ready), 32'd1);
    endtask

    // Apply one table vector: command-cycle pins, accept-to-ready gap, NOP reversion.
    task automatic apply(input int i);
        vec_t v;
        int   gap;
        v = vecs[i];
        @(negedge clk1);
        wait_ready($sformatf("v%0d", i));
        valid   = 1'b1;
        cmd     = v.cmd;
        rank    = v.rank;
        ba_in   = v.ba;
        addr_in = v.addr;
        mr_sel  = v.mr;
        @(posedge clk1);
        #1;
        valid = 1'b0;
        chk($sformatf("v%0d_pins", i), pins(), mkp(v.e_cke, v.e_cs, v.e_rcw, v.e_ba, v.e_addr, v.e_ill));
        gap = 1;
        while (!ready && gap < 2000) begin
            @(posedge clk1);
            #1;
            gap++;
        end
        chk($sformatf("v%0d_gap", i), 32'(gap), 32'(v.e_gap));
        @(posedge clk1);
        #1;
        chk($sformatf("v%0d_nop", i), pins(), mkp(v.e_cke, v.e_cs, 3'b111, v.e_ba, v.e_addr, 1'b0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int m;
        //            cmd    rk    ba    addr      mr     cke   cs     rcw     ba    addr      ill   gap
        vecs[0]  = '{4'd8,  2'd0, 3'd0, 14'h0000, 2'd0, 1'b0, 2'b11, 3'b111, 3'd0, 14'h0000, 1'b0, 1};
        vecs[1]  = '{4'd1,  2'd0, 3'd0, 14'h0000, 2'd1, 1'b0, 2'b11, 3'b111, 3'd0, 14'h0000, 1'b1, 1};
        vecs[2]  = '{4'd9,  2'd0, 3'd0, 14'h0000, 2'd0, 1'b1, 2'b00, 3'b111, 3'd0, 14'h0000, 1'b0, 1};
        vecs[3]  = '{4'd1,  2'd0, 3'd0, 14'h0000, 2'd2, 1'b1, 2'b10, 3'b000, 3'd2, 14'h0018, 1'b0, 12};
        vecs[4]  = '{4'd1,  2'd1, 3'd0, 14'h0000, 2'd0, 1'b1, 2'b01, 3'b000, 3'd0, 14'h1D70, 1'b0, 12};
        vecs[5]  = '{4'd7,  2'd0, 3'd5, 14'h3FFF, 2'd0, 1'b1, 2'b10, 3'b110, 3'd0, 14'h0400, 1'b0, 512};
        vecs[6]  = '{4'd2,  2'd1, 3'd7, 14'h1111, 2'd0, 1'b1, 2'b01, 3'b001, 3'd0, 14'h0400, 1'b0, 88};
        vecs[7]  = '{4'd3,  2'd0, 3'd5, 14'h0400, 2'd0, 1'b1, 2'b10, 3'b010, 3'd5, 14'h0400, 1'b0, 6};
        vecs[8]  = '{4'd4,  2'd1, 3'd3, 14'h1234, 2'd0, 1'b1, 2'b01, 3'b011, 3'd3, 14'h1234, 1'b0, 6};
        vecs[9]  = '{4'd5,  2'd1, 3'd3, 14'h0010, 2'd0, 1'b1, 2'b01, 3'b100, 3'd3, 14'h0010, 1'b0, 1};
        vecs[10] = '{4'd6,  2'd0, 3'd2, 14'h0408, 2'd0, 1'b1, 2'b10, 3'b101, 3'd2, 14'h0408, 1'b0, 1};
        vecs[11] = '{4'd0,  2'd1, 3'd7, 14'h3FFF, 2'd3, 1'b1, 2'b10, 3'b111, 3'd2, 14'h0408, 1'b0, 1};
        vecs[12] = '{4'd12, 2'd0, 3'd1, 14'h0001, 2'd0, 1'b1, 2'b10, 3'b111, 3'd2, 14'h0408, 1'b1, 1};
        vecs[13] = '{4'd15, 2'd1, 3'd1, 14'h0001, 2'd0, 1'b1, 2'b10, 3'b111, 3'd2, 14'h0408, 1'b1, 1};
        vecs[14] = '{4'd8,  2'd1, 3'd0, 14'h0000, 2'd0, 1'b0, 2'b11, 3'b111, 3'd0, 14'h0000, 1'b0, 1};
        vecs[15] = '{4'd4,  2'd0, 3'd3, 14'h1234, 2'd0, 1'b0, 2'b11, 3'b111, 3'd0, 14'h0000, 1'b1, 1};
        vecs[16] = '{4'd9,  2'd0, 3'd0, 14'h0000, 2'd0, 1'b1, 2'b00, 3'b111, 3'd0, 14'h0000, 1'b0, 1};

        // reset state
        rst = 1'b1;
        repeat (3) @(posedge clk1);
        #1;
        chk("reset_pins", pins(), mkp(1'b0, 2'b11, 3'b111, 3'd0, 14'h0, 1'b0));
        chk("reset_ready", 32'(ready), 32'd0);
        @(negedge clk1);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 32'(ready), 32'd1);

        for (int i = 0; i < NVEC; i++) apply(i);

        // RD x3 with valid held high and T_CCD=1: one RD per cycle, ready stays high
        @(negedge clk1);
        wait_ready("rd3");
        valid = 1'b1;
        cmd   = 4'd6;
        rank  = 2'd1;
        ba_in = 3'd1;
        for (int k = 0; k < 3; k++) begin
            addr_in = 14'(8 * (k + 1));
            @(posedge clk1);
            #1;
            chk($sformatf("rd3_pins%0d", k), pins(), mkp(1'b1, 2'b01, 3'b101, 3'd1, 14'(8 * (k + 1)), 1'b0));
            chk($sformatf("rd3_ready%0d", k), 32'(ready), 32'd1);
        end
        valid = 1'b0;
        @(posedge clk1);
        #1;
        chk("rd3_nop", pins(), mkp(1'b1, 2'b01, 3'b111, 3'd1, 14'h0018, 1'b0));

        // ZQCL then MRS held valid: MRS must not be accepted before 512 cycles
        @(negedge clk1);
        wait_ready("zq_hold");
        valid   = 1'b1;
        cmd     = 4'd7;
        rank    = 2'd0;
        ba_in   = 3'd6;
        addr_in = 14'h3FFF;
        @(posedge clk1);
        #1;
        chk("zq_pins", pins(), mkp(1'b1, 2'b10, 3'b110, 3'd0, 14'h0400, 1'b0));
        cmd    = 4'd1;
        mr_sel = 2'd3;
        m = 0;
        do begin
            @(posedge clk1);
            #1;
            m++;
        end while (!(ras_n == 1'b0 && cas_n == 1'b0 && we_n == 1'b0) && m < 1000);
        valid = 1'b0;
        chk("zq_hold_gap", 32'(m), 32'd512);
        chk("zq_hold_mrs_pins", pins(), mkp(1'b1, 2'b10, 3'b000, 3'd3, 14'h0000, 1'b0));

        // reset asserted in the middle of a REF wait
        @(negedge clk1);
        wait_ready("ref_rst");
        valid = 1'b1;
        cmd   = 4'd2;
        rank  = 2'd0;
        @(posedge clk1);
        #1;
        valid = 1'b0;
        chk("ref_pins", pins(), mkp(1'b1, 2'b10, 3'b001, 3'd3, 14'h0000, 1'b0));
        repeat (50) @(posedge clk1);
        @(negedge clk1);
        rst = 1'b1;
        #1;
        chk("ref_rst_ready", 32'(ready), 32'd0);
        @(posedge clk1);
        #1;
        chk("ref_rst_pins", pins(), mkp(1'b0, 2'b11, 3'b111, 3'd0, 14'h0, 1'b0));
        @(negedge clk1);
        rst = 1'b0;
        #1;
        chk("ref_rst_ready_after", 32'(ready), 32'd1);

        // three-rank instance: out-of-range rank is flagged, in-range rank encodes
        @(negedge clk1);
        valid3 = 1'b1;
        cmd    = 4'd9;
        @(posedge clk1);
        #1;
        chk("r3_powerup", pins3(), 32'({1'b1, 3'b000, 3'b111, 3'd0, 14'h0, 1'b0}));
        cmd     = 4'd4;
        rank    = 2'd3;
        ba_in   = 3'd1;
        addr_in = 14'h0005;
        @(posedge clk1);
        #1;
        chk("r3_bad_rank", pins3(), 32'({1'b1, 3'b000, 3'b111, 3'd0, 14'h0, 1'b1}));
        chk("r3_bad_rank_ready", 32'(ready3), 32'd1);
        rank = 2'd2;
        @(posedge clk1);
        #1;
        valid3 = 1'b0;
        chk("r3_act_rank2", pins3(), 32'({1'b1, 3'b011, 3'b011, 3'd1, 14'h0005, 1'b0}));
        chk("r3_act_busy", 32'(ready3), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
